// File: rtl/reg_file_access_ctrl.sv
// Register-file port initiator: serialises one decode request (write, then up to two reads)
// onto the single op/rw/reg_idx port and returns the read operands via a valid/ready response.
module reg_file_access_ctrl #(
   parameter int REG_IDX_WIDTH = 5,
   parameter int DATA_WIDTH    = 32,
   parameter int SKIP_X0       = 1
) (
   input  logic                     sys_clk,
   input  logic                     sys_rst,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_rs1_en,
   input  logic [REG_IDX_WIDTH-1:0] req_rs1,
   input  logic                     req_rs2_en,
   input  logic [REG_IDX_WIDTH-1:0] req_rs2,
   input  logic                     req_wr_en,
   input  logic [REG_IDX_WIDTH-1:0] req_rd,
   input  logic [DATA_WIDTH-1:0]    req_wdata,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [DATA_WIDTH-1:0]    rsp_rs1_data,
   output logic [DATA_WIDTH-1:0]    rsp_rs2_data,
   output logic                     rf_op,
   output logic                     rf_rw,
   output logic [REG_IDX_WIDTH-1:0] rf_reg_idx,
   output logic [DATA_WIDTH-1:0]    rf_data_w,
   input  logic [DATA_WIDTH-1:0]    rf_data_r,
   output logic [2:0]               dbg_state
);

   // Handshakes: a transfer happens on a posedge where valid && ready are both high.
   // req_ready is high only in IDLE; rsp_valid stays high in RSP until rsp_ready is seen.
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_WR   = 3'd1,
      S_RD1  = 3'd2,
      S_RD2  = 3'd3,
      S_RSP  = 3'd4
   } state_t;

   state_t state, state_nxt;

   logic                     l_rs1_en, l_rs2_en, l_wr_en;
   logic [REG_IDX_WIDTH-1:0] l_rs1, l_rs2, l_rd;
   logic [DATA_WIDTH-1:0]    l_wdata;
   logic [DATA_WIDTH-1:0]    rs1_q, rs2_q;
   logic                     accept;
   logic                     in_wr, in_rd1, in_rd2;
   logic                     iss_rd1, iss_rd2;

   function automatic logic issues(input logic en, input logic [REG_IDX_WIDTH-1:0] idx);
      return en && !((SKIP_X0 != 0) && (idx == '0));
   endfunction

   assign accept  = (state == S_IDLE) && req_valid;
   assign in_wr   = issues(req_wr_en, req_rd);
   assign in_rd1  = issues(req_rs1_en, req_rs1);
   assign in_rd2  = issues(req_rs2_en, req_rs2);
   assign iss_rd1 = issues(l_rs1_en, l_rs1);
   assign iss_rd2 = issues(l_rs2_en, l_rs2);

   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (req_valid) begin
               if (in_wr)       state_nxt = S_WR;
               else if (in_rd1) state_nxt = S_RD1;
               else if (in_rd2) state_nxt = S_RD2;
               else             state_nxt = S_RSP;
            end
         end
         S_WR: begin
            if (iss_rd1)      state_nxt = S_RD1;
            else if (iss_rd2) state_nxt = S_RD2;
            else              state_nxt = S_RSP;
         end
         S_RD1:   state_nxt = iss_rd2 ? S_RD2 : S_RSP;
         S_RD2:   state_nxt = S_RSP;
         S_RSP:   state_nxt = rsp_ready ? S_IDLE : S_RSP;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready  = (state == S_IDLE);
      rsp_valid  = (state == S_RSP);
      rf_op      = 1'b0;
      rf_rw      = 1'b0;
      rf_reg_idx = '0;
      rf_data_w  = '0;
      case (state)
         S_WR: begin
            rf_op      = 1'b1;
            rf_rw      = 1'b1;
            rf_reg_idx = l_rd;
            rf_data_w  = l_wdata;
         end
         S_RD1: begin
            rf_op      = 1'b1;
            rf_reg_idx = l_rs1;
         end
         S_RD2: begin
            rf_op      = 1'b1;
            rf_reg_idx = l_rs2;
         end
         default: ;
      endcase
   end

   // Request fields are captured once; the rf_* port is driven only from these copies.
   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         l_rs1_en <= 1'b0;
         l_rs1    <= '0;
         l_rs2_en <= 1'b0;
         l_rs2    <= '0;
         l_wr_en  <= 1'b0;
         l_rd     <= '0;
         l_wdata  <= '0;
      end else if (accept) begin
         l_rs1_en <= req_rs1_en;
         l_rs1    <= req_rs1;
         l_rs2_en <= req_rs2_en;
         l_rs2    <= req_rs2;
         l_wr_en  <= req_wr_en;
         l_rd     <= req_rd;
         l_wdata  <= req_wdata;
      end
   end

   // Read data is valid from the mid-cycle negedge, so it is taken on the edge leaving RD1/RD2.
   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         rs1_q <= '0;
         rs2_q <= '0;
      end else if (accept) begin
         rs1_q <= '0;
         rs2_q <= '0;
      end else if (state == S_RD1) begin
         rs1_q <= rf_data_r;
      end else if (state == S_RD2) begin
         rs2_q <= rf_data_r;
      end
   end

   assign rsp_rs1_data = rs1_q;
   assign rsp_rs2_data = rs2_q;
   assign dbg_state    = state;

endmodule
